stopwatch_controller: RTL and testbench

Sequencing controller for the stopwatch display path. Turns single-cycle button pulses (start/stop, lap, clear) into a run/pause/overflow state machine. Derives a 1 Hz time base from the 50 MHz board clock and maintains an MM:SS count. Drives the minutes/seconds inputs of seven_segment_driver, with a lap-freeze feature.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/tick_generator.sv | 38 +++
 rtl/stopwatch_controller.sv | 118 +++++++++++
 tb/tb_stopwatch_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encodings and count limits for the stopwatch datapath.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_PAUSE    = 2'd2,
      ST_OVERFLOW = 2'd3
   } state_e;

   localparam int MAX_SECONDS = 59;
   localparam int MAX_MINUTES = 99;
   localparam int SEC_W       = 7;
   localparam int MIN_W       = 7;

endpackage

// File: rtl/tick_generator.sv
// Enable-gated prescaler producing a one-cycle tick every TICKS_PER_SEC cycles.
module tick_generator #(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Tick is combinational so the count updates on the wrap edge itself.
   assign tick = enable && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/stopwatch_controller.sv
// Run/pause/overflow sequencer with MM:SS count and lap-freeze display mux.
module stopwatch_controller
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int MAX_MINUTES   = stopwatch_pkg::MAX_MINUTES,
   parameter int MAX_SECONDS   = stopwatch_pkg::MAX_SECONDS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_stop_pulse,
   input  logic             lap_pulse,
   input  logic             clear_pulse,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic             running,
   output logic             lap_active,
   output logic             overflow
);

   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(MAX_SECONDS);
   localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MINUTES);

   state_e           state_q, state_d;
   logic [MIN_W-1:0] min_q, min_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [MIN_W-1:0] lap_min_q, lap_min_d;
   logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
   logic             lap_act_q, lap_act_d;
   logic             tick;

   tick_generator #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_tick (
      .clock (clock),
      .reset (reset),
      .enable(state_q == ST_RUN),
      .clear (clear_pulse),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      sec_d     = sec_q;
      lap_min_d = lap_min_q;
      lap_sec_d = lap_sec_q;
      lap_act_d = lap_act_q;

      if (clear_pulse) begin
         state_d   = ST_IDLE;
         min_d     = '0;
         sec_d     = '0;
         lap_act_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_stop_pulse) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (start_stop_pulse) state_d = ST_PAUSE;
               // Terminal tick freezes the count rather than wrapping.
               if (tick) begin
                  if (min_q == MIN_LAST && sec_q == SEC_LAST) begin
                     state_d = ST_OVERFLOW;
                  end else if (sec_q == SEC_LAST) begin
                     sec_d = '0;
                     min_d = min_q + 1'b1;
                  end else begin
                     sec_d = sec_q + 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (start_stop_pulse) state_d = ST_RUN;
            end
            ST_OVERFLOW: begin
               state_d = ST_OVERFLOW;
            end
         endcase

         if (lap_pulse) begin
            if (lap_act_q) begin
               lap_act_d = 1'b0;
            end else if (state_q == ST_RUN || state_q == ST_PAUSE) begin
               lap_min_d = min_q;
               lap_sec_d = sec_q;
               lap_act_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         min_q     <= '0;
         sec_q     <= '0;
         lap_min_q <= '0;
         lap_sec_q <= '0;
         lap_act_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         lap_min_q <= lap_min_d;
         lap_sec_q <= lap_sec_d;
         lap_act_q <= lap_act_d;
      end
   end

   assign minutes    = lap_act_q ? lap_min_q : min_q;
   assign seconds    = lap_act_q ? lap_sec_q : sec_q;
   assign lap_active = lap_act_q;
   assign running    = (state_q == ST_RUN);
   assign overflow   = (state_q == ST_OVERFLOW);

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with a 4-cycle second.
module tb_stopwatch_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start_stop_pulse = 1'b0;
   logic       lap_pulse = 1'b0;
   logic       clear_pulse = 1'b0;
   logic [6:0] minutes;
   logic [6:0] seconds;
   logic       running;
   logic       lap_active;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   stopwatch_controller #(
      .TICKS_PER_SEC(4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start_stop_pulse(start_stop_pulse),
      .lap_pulse       (lap_pulse),
      .clear_pulse     (clear_pulse),
      .minutes         (minutes),
      .seconds         (seconds),
      .running         (running),
      .lap_active      (lap_active),
      .overflow        (overflow)
   );

   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press_ss();
      start_stop_pulse = 1'b1;
      cyc(1);
      start_stop_pulse = 1'b0;
   endtask

   task automatic press_lap();
      lap_pulse = 1'b1;
      cyc(1);
      lap_pulse = 1'b0;
   endtask

   task automatic press_clr();
      clear_pulse = 1'b1;
      cyc(1);
      clear_pulse = 1'b0;
   endtask

   task automatic chk(input string tag, input int m, input int s,
                      input logic r, input logic l, input logic o);
      logic [16:0] obs;
      logic [16:0] exp;
      obs = {minutes, seconds, running, lap_active, overflow};
      exp = {7'(m), 7'(s), r, l, o};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d:%0d r%b l%b o%b expected=%0d:%0d r%b l%b o%b",
                tag, minutes, seconds, running, lap_active, overflow,
                m, s, r, l, o);
      end
   endtask

   initial begin
      // reset state
      cyc(2);
      chk("reset_hold", 0, 0, 0, 0, 0);
      reset = 1'b0;
      cyc(5);
      chk("idle", 0, 0, 0, 0, 0);

      // 1: first tick latency and minute rollover
      press_ss();
      chk("t1_start", 0, 0, 1, 0, 0);
      cyc(3);
      chk("t1_pre_tick", 0, 0, 1, 0, 0);
      cyc(1);
      chk("t1_first_tick", 0, 1, 1, 0, 0);
      cyc(235);
      chk("t1_0059", 0, 59, 1, 0, 0);
      cyc(1);
      chk("t1_0100", 1, 0, 1, 0, 0);
      press_clr();
      chk("t1_clear", 0, 0, 0, 0, 0);

      // 2: pause keeps partial second
      press_ss();
      cyc(5);
      chk("t2_0001", 0, 1, 1, 0, 0);
      press_ss();
      chk("t2_paused", 0, 1, 0, 0, 0);
      cyc(20);
      chk("t2_frozen", 0, 1, 0, 0, 0);
      press_ss();
      chk("t2_resume", 0, 1, 1, 0, 0);
      cyc(1);
      chk("t2_resume1", 0, 1, 1, 0, 0);
      cyc(1);
      chk("t2_resume2", 0, 2, 1, 0, 0);
      press_clr();

      // 3: overflow
      press_ss();
      cyc(23996);
      chk("t3_9959", 99, 59, 1, 0, 0);
      cyc(3);
      chk("t3_9959_hold", 99, 59, 1, 0, 0);
      cyc(1);
      chk("t3_overflow", 99, 59, 0, 0, 1);
      cyc(8);
      chk("t3_ovf_hold", 99, 59, 0, 0, 1);
      press_ss();
      chk("t3_ss_ignored", 99, 59, 0, 0, 1);
      cyc(8);
      chk("t3_ss_ignored2", 99, 59, 0, 0, 1);
      press_clr();
      chk("t3_clear", 0, 0, 0, 0, 0);

      // 4: lap freeze and release
      press_ss();
      cyc(20);
      chk("t4_0005", 0, 5, 1, 0, 0);
      press_lap();
      chk("t4_lap_on", 0, 5, 1, 1, 0);
      cyc(12);
      chk("t4_frozen", 0, 5, 1, 1, 0);
      press_lap();
      chk("t4_lap_off", 0, 8, 1, 0, 0);
      press_clr();

      // 5: simultaneous events
      clear_pulse = 1'b1;
      start_stop_pulse = 1'b1;
      cyc(1);
      clear_pulse = 1'b0;
      start_stop_pulse = 1'b0;
      chk("t5_clr_ss", 0, 0, 0, 0, 0);
      cyc(8);
      chk("t5_still_idle", 0, 0, 0, 0, 0);
      press_ss();
      cyc(35);
      chk("t5_0008", 0, 8, 1, 0, 0);
      cyc(4);
      chk("t5_0009", 0, 9, 1, 0, 0);
      press_lap();
      chk("t5_lap_tick", 0, 9, 1, 1, 0);
      press_lap();
      chk("t5_release", 0, 10, 1, 0, 0);
      press_clr();
      press_lap();
      chk("t5_lap_idle", 0, 0, 0, 0, 0);

      // 6: reset mid-run with lap held
      press_ss();
      cyc(3016);
      chk("t6_1234", 12, 34, 1, 0, 0);
      press_lap();
      chk("t6_lap", 12, 34, 1, 1, 0);
      reset = 1'b1;
      cyc(1);
      chk("t6_reset", 0, 0, 0, 0, 0);
      reset = 1'b0;
      cyc(4);
      chk("t6_idle", 0, 0, 0, 0, 0);
      press_ss();
      cyc(3);
      chk("t6_pre_tick", 0, 0, 1, 0, 0);
      cyc(1);
      chk("t6_first_tick", 0, 1, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
